// File: rtl/sub_n_bit_signed_serial_pkg.sv
// Shared FSM encoding and sizing helper for the serial signed subtractor.
// Also pulled in by the ALU top for its own state decode.
package sub_n_bit_signed_serial_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/sub_n_bit_signed_serial_fa.sv
// One-bit full adder used as the serial bit cell.
// Ports: a, b, cin in; s (sum), cout (carry) out.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_n_bit_signed_serial.sv
// Bit-serial signed subtractor, LSB first: result = a - b in n+1 bits.
// Ports: clk, rst_n, in_valid/in_ready/a/b, out_valid/out_ready/result, busy.
module sub_n_bit_signed_serial
  import sub_n_bit_signed_serial_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n:0]   result,
  output logic         busy
);

  localparam int CW = cnt_w(n);

  logic [1:0]    state_q, state_d;
  logic [n-1:0]  a_sh_q, a_sh_d;
  logic [n-1:0]  b_sh_q, b_sh_d;
  logic [n-1:0]  acc_q, acc_d;
  logic          a_sign_q, a_sign_d;
  logic          b_sign_q, b_sign_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [n:0]    result_q, result_d;

  logic s_bit;
  logic c_bit;

  full_adder_1bit u_fa (
    .a    (a_sh_q[0]),
    .b    (~b_sh_q[0]),
    .cin  (c_q),
    .s    (s_bit),
    .cout (c_bit)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    a_sign_d    = a_sign_q;
    b_sign_d    = b_sign_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          a_sign_d = a[n-1];
          b_sign_d = b[n-1];
          c_d      = 1'b1;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      (state_q == SHIFT): begin
        acc_d  = {s_bit, acc_q[n-1:1]};
        a_sh_d = {1'b0, a_sh_q[n-1:1]};
        b_sh_d = {1'b0, b_sh_q[n-1:1]};
        c_d    = c_bit;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(n-1)) begin
          // bit n extends the sign of a + ~b + 1
          result_d = {a_sign_q ^ ~b_sign_q ^ c_bit,
                      s_bit, acc_q[n-1:1]};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      (state_q == DONE): begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      a_sign_q    <= a_sign_d;
      b_sign_q    <= b_sign_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_sub_n_bit_signed_serial.sv
// Directed bench for the serial subtractor, n=4 and n=8 instances.
// Table of vectors plus backpressure and async-reset sequences.
module tb_sub_n_bit_signed_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv4 = 1'b0, or4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir4, ov4, busy4;
  logic [4:0] r4;

  logic       iv8 = 1'b0, or8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ir8, ov8, busy8;
  logic [8:0] r8;

  sub_n_bit_signed_serial #(.n(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4),
    .result(r4), .busy(busy4)
  );

  sub_n_bit_signed_serial #(.n(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8),
    .result(r8), .busy(busy8)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp;
  } vec4_t;

  vec4_t tbl[7];

  task automatic wait_ov4(output int lat);
    lat = 0;
    while (ov4 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op4(input string nm, input logic [3:0] a,
                     input logic [3:0] b, input logic [4:0] exp);
    int lat;
    @(negedge clk);
    check({nm, "_in_ready"}, 32'(ir4), 32'd1);
    a4 = a; b4 = b; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    a4 = ~a; b4 = ~b;
    check({nm, "_busy"}, 32'(busy4), 32'd1);
    wait_ov4(lat);
    check({nm, "_latency"}, 32'(lat), 32'd4);
    check({nm, "_result"}, 32'(r4), 32'(exp));
    @(posedge clk); #1;
    check({nm, "_ov_drop"}, 32'(ov4), 32'd0);
    check({nm, "_ready_back"}, 32'(ir4), 32'd1);
  endtask

  task automatic op8(input string nm, input logic [7:0] a,
                     input logic [7:0] b, input logic [8:0] exp);
    int lat;
    @(negedge clk);
    a8 = a; b8 = b; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'd8);
    check({nm, "_result"}, 32'(r8), 32'(exp));
    @(posedge clk); #1;
    check({nm, "_ready_back"}, 32'(ir8), 32'd1);
  endtask

  initial begin
    int lat;
    logic [4:0] hold;
    tbl[0] = '{4'd3,  4'b1100, 5'b00111};
    tbl[1] = '{4'b1000, 4'd7,  5'b10001};
    tbl[2] = '{4'd7,  4'b1000, 5'b01111};
    tbl[3] = '{4'b1000, 4'b1000, 5'b00000};
    tbl[4] = '{4'd0,  4'd0,    5'b00000};
    tbl[5] = '{4'b1111, 4'd1,  5'b11110};
    tbl[6] = '{4'd2,  4'd5,    5'b11101};

    #12;
    check("rst_ov", 32'(ov4), 32'd0);
    check("rst_ready", 32'(ir4), 32'd1);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_result", 32'(r4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      op4($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp);

    // backpressure in DONE: 6 - 3 = 3
    or4 = 1'b0;
    @(negedge clk);
    a4 = 4'd6; b4 = 4'd3; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    wait_ov4(lat);
    check("bp_latency", 32'(lat), 32'd4);
    hold = r4;
    check("bp_result", 32'(hold), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a4 = 4'd1; b4 = 4'd7; iv4 = k[0];
      check($sformatf("bp_ov%0d", k), 32'(ov4), 32'd1);
      check($sformatf("bp_ir%0d", k), 32'(ir4), 32'd0);
      check($sformatf("bp_res%0d", k), 32'(r4), 32'd3);
    end
    @(negedge clk);
    iv4 = 1'b0;
    or4 = 1'b1;
    @(posedge clk); #1;
    check("bp_ov_drop", 32'(ov4), 32'd0);
    check("bp_idle", 32'(ir4), 32'd1);
    check("bp_res_kept", 32'(r4), 32'd3);
    @(posedge clk); #1;
    check("bp_no_start", 32'(busy4), 32'd0);

    // async reset while processing bit 2
    @(negedge clk);
    a4 = 4'b1111; b4 = 4'd7; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_ov", 32'(ov4), 32'd0);
    check("ar_ready", 32'(ir4), 32'd1);
    check("ar_busy", 32'(busy4), 32'd0);
    check("ar_result", 32'(r4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op4("ar_after", 4'd5, 4'd2, 5'b00011);

    op8("n8_pos", 8'd127, 8'h80, 9'h0FF);
    op8("n8_neg", 8'h80, 8'd127, 9'h101);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
